// File: rtl/tt_out_serializer.sv
// Capture FIFO plus MSB-first bit serializer for the design's io_o bus.
// Captured words queue in a DEPTH-entry FIFO. Each word is then shifted out on a valid/ready serial link.
module tt_out_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       io_o_data,
    input  logic                   capture,
    input  logic                   ser_ready,
    output logic                   ser_data,
    output logic                   ser_valid,
    output logic                   ser_last,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [PW:0]   FULL     = (PW + 1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Serial link: a bit moves on any edge where ser_valid and ser_ready are both high.
    // The producer holds ser_data, ser_valid and ser_last steady until that edge.
    // ser_valid never depends on ser_ready.
    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;

    logic fifo_empty;
    logic fifo_full;
    logic xfer;
    logic at_last;
    logic pop;
    logic push;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL);
    assign at_last    = (bit_cnt == LAST_BIT);
    assign xfer       = ser_valid && ser_ready;
    // Pop decisions use the count from before this edge's push.
    // A full FIFO can therefore still take a sample on the edge its head is handed to the shifter.
    assign pop        = !fifo_empty && ((state == IDLE) || (xfer && at_last));
    assign push       = capture && (!fifo_full || pop);

    assign ser_valid = (state == SHIFT);
    assign ser_data  = shreg[WIDTH-1];
    assign ser_last  = (state == SHIFT) && at_last;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= io_o_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (capture && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        if (!at_last) begin
                            shreg   <= {shreg[WIDTH-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (pop) begin
                            shreg   <= mem[rd_ptr];
                            bit_cnt <= '0;
                        end else begin
                            // Clear the shifter so ser_data rests at 0 while idle.
                            shreg   <= '0;
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_out_serializer.sv
// Randomized plus directed bench for tt_out_serializer.
// It checks against a queue-based model of the captured words and of the bits in flight.
module tb_tt_out_serializer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] io_o_data;
    logic             capture;
    logic             ser_ready;
    logic             ser_data;
    logic             ser_valid;
    logic             ser_last;
    logic [2:0]       fifo_count;
    logic             overflow;

    int checks;
    int errors;

    // Model state.
    logic [WIDTH-1:0] fifo_q[$];
    logic             cur_bits[$];
    logic             m_ovf;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] col_word;
    int               col_n;

    tt_out_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .io_o_data  (io_o_data),
        .capture    (capture),
        .ser_ready  (ser_ready),
        .ser_data   (ser_data),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_model();
        fifo_q.delete();
        cur_bits.delete();
        exp_q.delete();
        m_ovf    = 1'b0;
        col_word = '0;
        col_n    = 0;
    endtask

    task automatic compare_outputs();
        logic m_valid;
        m_valid = (cur_bits.size() != 0);
        check("valid", 32'(ser_valid), 32'(m_valid));
        check("last", 32'(ser_last), 32'(m_valid && cur_bits.size() == 1));
        if (m_valid) begin
            check("data", 32'(ser_data), 32'(cur_bits[0]));
        end
        check("count", 32'(fifo_count), 32'(fifo_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Called just after a falling edge. Applies the inputs, steps the model across the rising edge, then checks.
    task automatic cycle(input logic cap, input logic [WIDTH-1:0] d, input logic rdy);
        logic m_valid, m_xfer, m_pop, m_push;
        logic [WIDTH-1:0] w;
        capture   = cap;
        io_o_data = d;
        ser_ready = rdy;
        if (ser_valid && rdy) begin
            col_word = {col_word[WIDTH-2:0], ser_data};
            col_n++;
            if (ser_last) begin
                check("word_bits", 32'(col_n), 32'(WIDTH));
                if (exp_q.size() == 0) begin
                    check("word_extra", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("word", 32'(col_word), 32'(exp_q.pop_front()));
                end
                col_n = 0;
            end
        end
        m_valid = (cur_bits.size() != 0);
        m_xfer  = m_valid && rdy;
        m_pop   = (fifo_q.size() != 0) && (!m_valid || (m_xfer && cur_bits.size() == 1));
        m_push  = cap && ((fifo_q.size() < DEPTH) || m_pop);
        @(posedge clk);
        if (m_xfer) begin
            void'(cur_bits.pop_front());
        end
        if (m_pop) begin
            w = fifo_q.pop_front();
            for (int i = WIDTH - 1; i >= 0; i--) cur_bits.push_back(w[i]);
        end
        if (m_push) begin
            fifo_q.push_back(d);
            exp_q.push_back(d);
        end else if (cap) begin
            m_ovf = 1'b1;
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle_cycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy);
    endtask

    // Assert reset partway into the cycle and check that the outputs clear without a clock edge.
    task automatic reset_dut();
        @(negedge clk);
        #2;
        reset     = 1'b1;
        capture   = 1'b0;
        ser_ready = 1'b0;
        #1;
        check("rst_data", 32'(ser_data), 32'd0);
        check("rst_valid", 32'(ser_valid), 32'd0);
        check("rst_last", 32'(ser_last), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        clear_model();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int pct;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        capture   = 1'b0;
        ser_ready = 1'b0;
        io_o_data = '0;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compare_outputs();
        idle_cycles(3, 1'b1);

        // Single word.
        cycle(1'b1, 8'b10110010, 1'b1);
        idle_cycles(12, 1'b1);

        // Back-to-back words.
        cycle(1'b1, 8'hA5, 1'b1);
        cycle(1'b1, 8'h3C, 1'b1);
        idle_cycles(20, 1'b1);

        // Backpressure.
        cycle(1'b1, 8'hF0, 1'b1);
        idle_cycles(1, 1'b1);
        idle_cycles(5, 1'b0);
        idle_cycles(12, 1'b1);

        // Mid-word reset, then overflow.
        cycle(1'b1, 8'h77, 1'b1);
        idle_cycles(4, 1'b1);
        reset_dut();
        idle_cycles(3, 1'b0);
        for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i), 1'b0);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        idle_cycles(50, 1'b1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO: push on the edge that moves the last bit of the in-flight word.
        reset_dut();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            cycle(cur_bits.size() == 1, 8'($urandom_range(0, 255)), 1'b1);
        end
        check("full_pp_count", 32'(fifo_count), 32'd4);
        check("full_pp_overflow", 32'(overflow), 32'd0);
        idle_cycles(50, 1'b1);

        // Random traffic.
        pct = 100;
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) pct = $urandom_range(0, 2) == 0 ? 20 : ($urandom_range(0, 1) == 0 ? 60 : 100);
            if (i == 1000) reset_dut();
            cycle($urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 99) < pct);
        end
        idle_cycles(60, 1'b1);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
